// File: rtl/video_timer_if.sv
// Pixel-timing bus between the video timer and its consumers.
// The timer drives the sync/position decodes; the consumer drives the pixel enable.
interface video_timer_if #(
    parameter int CW = 10,
    parameter int FW = 8
);
    logic          pix_en_i;
    logic          hsync_o;
    logic          vsync_o;
    logic          visible_o;
    logic [CW-1:0] position_x_o;
    logic [CW-1:0] position_y_o;
    logic          line_start_o;
    logic          frame_start_o;
    logic          vblank_o;
    logic [FW-1:0] frame_count_o;

    modport master (
        input  pix_en_i,
        output hsync_o, vsync_o, visible_o, position_x_o, position_y_o,
        output line_start_o, frame_start_o, vblank_o, frame_count_o
    );

    modport slave (
        output pix_en_i,
        input  hsync_o, vsync_o, visible_o, position_x_o, position_y_o,
        input  line_start_o, frame_start_o, vblank_o, frame_count_o
    );
endinterface

// File: rtl/video_timer.sv
// Raster timing generator: horizontal/vertical pixel counters plus frame counter,
// with all outputs decoded combinationally from the current counter state.
module video_timer #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int CW        = 10,
    parameter int FW        = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    video_timer_if.master     tmr
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    if (H_VISIBLE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
        V_VISIBLE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1 ||
        CW < 1 || FW < 1 ||
        (H_TOTAL - 1) > ((1 << CW) - 1) || (V_TOTAL - 1) > ((1 << CW) - 1))
    begin : g_param_check
        $error("video_timer: timing parameters invalid or do not fit in CW bits");
    end

    // Sync end bounds never exceed TOTAL-1 because every back porch is >= 1.
    localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_VIS_END  = CW'(H_VISIBLE);
    localparam logic [CW-1:0] V_VIS_END  = CW'(V_VISIBLE);
    localparam logic [CW-1:0] HS_START   = CW'(H_VISIBLE + H_FRONT);
    localparam logic [CW-1:0] HS_END     = CW'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [CW-1:0] VS_START   = CW'(V_VISIBLE + V_FRONT);
    localparam logic [CW-1:0] VS_END     = CW'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [CW-1:0] h_q, h_d;
    logic [CW-1:0] v_q, v_d;
    logic [FW-1:0] frame_q, frame_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            h_q     <= '0;
            v_q     <= '0;
            frame_q <= '0;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            frame_q <= frame_d;
        end
    end

    always_comb begin
        h_d     = h_q;
        v_d     = v_q;
        frame_d = frame_q;
        if (tmr.pix_en_i) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                if (v_q == V_LAST) begin
                    v_d     = '0;
                    frame_d = frame_q + 1'b1;
                end else begin
                    v_d = v_q + 1'b1;
                end
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    logic in_hsync;
    logic in_vsync;

    always_comb begin
        in_hsync = (h_q >= HS_START) && (h_q < HS_END);
        in_vsync = (v_q >= VS_START) && (v_q < VS_END);
    end

    assign tmr.hsync_o       = in_hsync ? HSYNC_POL : ~HSYNC_POL;
    assign tmr.vsync_o       = in_vsync ? VSYNC_POL : ~VSYNC_POL;
    assign tmr.visible_o     = (h_q < H_VIS_END) && (v_q < V_VIS_END);
    assign tmr.position_x_o  = h_q;
    assign tmr.position_y_o  = v_q;
    assign tmr.line_start_o  = (h_q == '0);
    assign tmr.frame_start_o = (h_q == '0) && (v_q == '0);
    assign tmr.vblank_o      = (v_q >= V_VIS_END);
    assign tmr.frame_count_o = frame_q;

endmodule

// File: tb/tb_video_timer.sv
// Directed bench: default 640x480 timing over the first lines, and a tiny
// 7x5 raster run for four full frames to cover vertical sync and frame wrap.
module tb_video_timer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rst_s_n = 1'b0;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    video_timer_if #(.CW(10), .FW(8)) bus ();
    video_timer_if #(.CW(4),  .FW(2)) sbus ();

    video_timer dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .tmr    (bus.master)
    );

    video_timer #(
        .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
        .V_VISIBLE(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CW(4), .FW(2)
    ) dut_s (
        .clk_i  (clk),
        .rst_ni (rst_s_n),
        .tmr    (sbus.master)
    );

    logic [9:0] hm, vm;

    task automatic step_model();
        if (hm == 10'd799) begin
            hm = 10'd0;
            vm = vm + 10'd1;
        end else begin
            hm = hm + 10'd1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rst_s_n = 1'b0;
        bus.pix_en_i = 1'b1;
        sbus.pix_en_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus.position_x_o !== 10'd0 || bus.position_y_o !== 10'd0) begin
            bad++; $display("FAIL reset_pos got=%0d/%0d want=0/0", bus.position_x_o, bus.position_y_o);
        end
        total++; if ({bus.visible_o, bus.line_start_o, bus.frame_start_o, bus.vblank_o} !== 4'b1110) begin
            bad++; $display("FAIL reset_flags got=%b want=1110", {bus.visible_o, bus.line_start_o, bus.frame_start_o, bus.vblank_o});
        end
        total++; if ({bus.hsync_o, bus.vsync_o} !== 2'b11 || bus.frame_count_o !== 8'd0) begin
            bad++; $display("FAIL reset_sync got=%b fc=%0d want=11 fc=0", {bus.hsync_o, bus.vsync_o}, bus.frame_count_o);
        end
        total++; if ({sbus.hsync_o, sbus.vsync_o} !== 2'b00) begin
            bad++; $display("FAIL reset_sync_pol1 got=%b want=00", {sbus.hsync_o, sbus.vsync_o});
        end
        sbus.pix_en_i = 1'b0;
    endtask

    task automatic test_hline();
        int hs_cnt = 0, hs_first = -1, hs_last = -1, vis_cnt = 0;
        int ls_cnt = 0, ls_prev = 0, ls_period = 0, fs_cnt = 0, pos_err = 0;
        rst_n = 1'b1;
        hm = 10'd0;
        vm = 10'd0;
        for (int i = 0; i < 1600; i++) begin
            if (bus.position_x_o !== hm || bus.position_y_o !== vm) pos_err++;
            if (bus.hsync_o === 1'b0) begin
                hs_cnt++;
                if (vm == 10'd0) begin
                    if (hs_first < 0) hs_first = int'(hm);
                    hs_last = int'(hm);
                end
            end
            if (bus.visible_o === 1'b1) vis_cnt++;
            if (hm == 10'd640 && vm == 10'd0) begin
                total++; if (bus.visible_o !== 1'b0) begin
                    bad++; $display("FAIL visible_h640 got=%b want=0", bus.visible_o);
                end
            end
            if (hm == 10'd639 && vm == 10'd0) begin
                total++; if (bus.visible_o !== 1'b1) begin
                    bad++; $display("FAIL visible_h639 got=%b want=1", bus.visible_o);
                end
            end
            if (bus.line_start_o === 1'b1) begin
                if (ls_cnt > 0) ls_period = i - ls_prev;
                ls_prev = i;
                ls_cnt++;
            end
            if (bus.frame_start_o === 1'b1) fs_cnt++;
            @(posedge clk);
            #1;
            step_model();
        end
        total++; if (pos_err != 0) begin
            bad++; $display("FAIL hline_position errors=%0d want=0", pos_err);
        end
        total++; if (hs_cnt != 192) begin
            bad++; $display("FAIL hsync_clocks got=%0d want=192", hs_cnt);
        end
        total++; if (hs_first != 656 || hs_last != 751) begin
            bad++; $display("FAIL hsync_window got=%0d..%0d want=656..751", hs_first, hs_last);
        end
        total++; if (vis_cnt != 1280) begin
            bad++; $display("FAIL visible_clocks got=%0d want=1280", vis_cnt);
        end
        total++; if (ls_cnt != 2 || ls_period != 800) begin
            bad++; $display("FAIL line_period got=%0d starts period=%0d want=2 starts period=800", ls_cnt, ls_period);
        end
        total++; if (fs_cnt != 1) begin
            bad++; $display("FAIL frame_start_count got=%0d want=1", fs_cnt);
        end
        total++; if (bus.position_x_o !== 10'd0 || bus.position_y_o !== 10'd2 || bus.vblank_o !== 1'b0) begin
            bad++; $display("FAIL hline_end got=%0d/%0d vb=%b want=0/2 vb=0", bus.position_x_o, bus.position_y_o, bus.vblank_o);
        end
    endtask

    task automatic test_pix_en();
        int hs_cnt = 0, pos_err = 0, hold_err = 0;
        logic prev_hs, prev_vis, prev_ls;
        for (int i = 0; i < 3200; i++) begin
            bus.pix_en_i = (i % 4 == 0);
            prev_hs  = bus.hsync_o;
            prev_vis = bus.visible_o;
            prev_ls  = bus.line_start_o;
            @(posedge clk);
            #1;
            if (bus.pix_en_i) step_model();
            else if (bus.hsync_o !== prev_hs || bus.visible_o !== prev_vis || bus.line_start_o !== prev_ls)
                hold_err++;
            if (bus.position_x_o !== hm || bus.position_y_o !== vm) pos_err++;
            if (bus.hsync_o === 1'b0) hs_cnt++;
        end
        bus.pix_en_i = 1'b1;
        total++; if (pos_err != 0) begin
            bad++; $display("FAIL pix_en_position errors=%0d want=0", pos_err);
        end
        total++; if (hold_err != 0) begin
            bad++; $display("FAIL pix_en_hold errors=%0d want=0", hold_err);
        end
        total++; if (hs_cnt != 384) begin
            bad++; $display("FAIL pix_en_hsync_clocks got=%0d want=384", hs_cnt);
        end
        total++; if (bus.position_x_o !== 10'd0 || bus.position_y_o !== 10'd3) begin
            bad++; $display("FAIL pix_en_end got=%0d/%0d want=0/3", bus.position_x_o, bus.position_y_o);
        end
    endtask

    task automatic test_async_reset();
        repeat (300) @(posedge clk);
        #1;
        total++; if (bus.position_x_o !== 10'd300 || bus.position_y_o !== 10'd3) begin
            bad++; $display("FAIL pre_reset_pos got=%0d/%0d want=300/3", bus.position_x_o, bus.position_y_o);
        end
        #3;
        rst_n = 1'b0;
        #1;
        total++; if (bus.position_x_o !== 10'd0 || bus.position_y_o !== 10'd0) begin
            bad++; $display("FAIL async_reset_pos got=%0d/%0d want=0/0", bus.position_x_o, bus.position_y_o);
        end
        total++; if ({bus.visible_o, bus.line_start_o, bus.frame_start_o, bus.vblank_o, bus.hsync_o, bus.vsync_o} !== 6'b111011) begin
            bad++; $display("FAIL async_reset_flags got=%b want=111011",
                {bus.visible_o, bus.line_start_o, bus.frame_start_o, bus.vblank_o, bus.hsync_o, bus.vsync_o});
        end
        @(posedge clk);
        #1;
        total++; if (bus.position_x_o !== 10'd0) begin
            bad++; $display("FAIL reset_hold_x got=%0d want=0", bus.position_x_o);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++; if (bus.position_x_o !== 10'd1 || bus.position_y_o !== 10'd0) begin
            bad++; $display("FAIL after_release got=%0d/%0d want=1/0", bus.position_x_o, bus.position_y_o);
        end
    endtask

    task automatic test_small_frames();
        int hs_hi = 0, hs_err = 0, vs_hi = 0, vs_err = 0, vis = 0, vb = 0, fs = 0;
        int pos_err = 0, fc_err = 0, h, v;
        rst_s_n = 1'b1;
        sbus.pix_en_i = 1'b1;
        for (int i = 0; i < 140; i++) begin
            h = i % 7;
            v = (i / 7) % 5;
            if (sbus.position_x_o !== 4'(h) || sbus.position_y_o !== 4'(v)) pos_err++;
            if (sbus.hsync_o === 1'b1) hs_hi++;
            if (sbus.hsync_o !== (h == 5)) hs_err++;
            if (sbus.vsync_o === 1'b1) vs_hi++;
            if (sbus.vsync_o !== (v == 3)) vs_err++;
            if (sbus.visible_o === 1'b1) vis++;
            if (sbus.vblank_o === 1'b1) vb++;
            if (sbus.frame_start_o === 1'b1) fs++;
            if (sbus.frame_count_o !== 2'((i / 35) % 4)) fc_err++;
            @(posedge clk);
            #1;
        end
        total++; if (pos_err != 0) begin
            bad++; $display("FAIL small_position errors=%0d want=0", pos_err);
        end
        total++; if (hs_hi != 20 || hs_err != 0) begin
            bad++; $display("FAIL small_hsync got=%0d clocks %0d misplaced want=20 clocks 0 misplaced", hs_hi, hs_err);
        end
        total++; if (vs_hi != 28 || vs_err != 0) begin
            bad++; $display("FAIL small_vsync got=%0d clocks %0d misplaced want=28 clocks 0 misplaced", vs_hi, vs_err);
        end
        total++; if (vis != 32 || vb != 84) begin
            bad++; $display("FAIL small_visible_vblank got=%0d/%0d want=32/84", vis, vb);
        end
        total++; if (fs != 4) begin
            bad++; $display("FAIL small_frame_start got=%0d want=4", fs);
        end
        total++; if (fc_err != 0) begin
            bad++; $display("FAIL small_frame_count errors=%0d want=0", fc_err);
        end
        total++; if (sbus.frame_count_o !== 2'd0 || sbus.frame_start_o !== 1'b1) begin
            bad++; $display("FAIL frame_count_wrap got=%0d fs=%b want=0 fs=1", sbus.frame_count_o, sbus.frame_start_o);
        end
    endtask

    initial begin
        hm = 10'd0;
        vm = 10'd0;
        bus.pix_en_i = 1'b0;
        sbus.pix_en_i = 1'b0;
        #1;
        test_reset();
        test_hline();
        test_pix_en();
        test_async_reset();
        test_small_frames();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/video_timer.md
VIDEO_TIMER -- requirements
Module: video_timer

Interface
REQ-001 Parameter H_VISIBLE, default 640, active pixels per line.
REQ-002 Parameter H_FRONT, default 16, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, default 96, horizontal sync width in pixels.
REQ-004 Parameter H_BACK, default 48, horizontal back porch in pixels.
REQ-005 Parameter V_VISIBLE, default 480, active lines per frame.
REQ-006 Parameter V_FRONT, default 10, vertical front porch in lines.
REQ-007 Parameter V_SYNC, default 2, vertical sync width in lines.
REQ-008 Parameter V_BACK, default 33, vertical back porch in lines.
REQ-009 Parameter HSYNC_POL, default 0, hsync asserted level (0 = active-low).
REQ-010 Parameter VSYNC_POL, default 0, vsync asserted level (0 = active-low).
REQ-011 Parameter CW, default 10, width of position outputs and internal counters.
REQ-012 Parameter FW, default 8, width of the frame counter.
REQ-013 clk_i  input  1  single clock; all state changes on its rising edge.
REQ-014 rst_ni  input  1  reset, asynchronous and active-low.
REQ-015 pix_en_i  input  1  pixel-advance enable; counters step only on clocks where it is high.
REQ-016 hsync_o  output  1  horizontal sync at HSYNC_POL level while asserted.
REQ-017 vsync_o  output  1  vertical sync at VSYNC_POL level while asserted.
REQ-018 visible_o  output  1  current pixel is inside the active area.
REQ-019 position_x_o  output  CW  current horizontal count.
REQ-020 position_y_o  output  CW  current vertical count.
REQ-021 line_start_o  output  1  current pixel is h = 0.
REQ-022 frame_start_o  output  1  current pixel is h = 0, v = 0.
REQ-023 vblank_o  output  1  current line is v >= V_VISIBLE.
REQ-024 frame_count_o  output  FW  completed frames since reset, modulo 2^FW.

Function
REQ-025 H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK and V_TOTAL = V_VISIBLE+V_FRONT+V_SYNC+V_BACK; elaboration SHALL fail if H_TOTAL-1 or V_TOTAL-1 exceeds 2^CW-1 or any parameter is < 1.
REQ-026 On a clock with pix_en_i high, h SHALL increment; at h = H_TOTAL-1 it SHALL wrap to 0 and v SHALL increment in the same edge.
REQ-027 When h wraps with v = V_TOTAL-1, v SHALL wrap to 0 and frame_count SHALL increment (wrapping 2^FW-1 -> 0) in the same edge.
REQ-028 With pix_en_i low, h, v, frame_count and all outputs SHALL hold.
REQ-029 All outputs SHALL be pure decodes of the current h, v and frame_count registers: zero latency, all mutually aligned to the same pixel.
REQ-030 hsync_o SHALL be asserted iff H_VISIBLE+H_FRONT <= h < H_VISIBLE+H_FRONT+H_SYNC.
REQ-031 vsync_o SHALL be asserted iff V_VISIBLE+V_FRONT <= v < V_VISIBLE+V_FRONT+V_SYNC, over every h of those lines.
REQ-032 visible_o SHALL be 1 iff h < H_VISIBLE and v < V_VISIBLE (strict on both axes).
REQ-033 position_x_o = h and position_y_o = v at all times, including blanking.
REQ-034 Counters SHALL never hold h >= H_TOTAL or v >= V_TOTAL.

Reset
REQ-035 While rst_ni is low, independent of clk_i: h = 0, v = 0, frame_count = 0.
REQ-036 Reset outputs: position 0/0, visible_o = 1, line_start_o = 1, frame_start_o = 1, vblank_o = 0, frame_count_o = 0, hsync_o = ~HSYNC_POL, vsync_o = ~VSYNC_POL.
REQ-037 Reset asserted mid-frame SHALL take effect immediately; first pix_en_i after release SHALL move to h = 1, v = 0.

Verification
REQ-038 Defaults, pix_en_i = 1, release reset -> hsync_o low exactly for h 656..751, 96 clocks per line; line period 800 clocks.
REQ-039 Defaults, run one frame -> vsync_o low exactly for v 490..491 (1600 clocks); frame_start_o high once per 420000 clocks; frame_count_o 0 -> 1 at that wrap.
REQ-040 Defaults -> visible_o high for h 0..639, low at h = 640; low for all of v = 480; 307200 visible clocks per frame.
REQ-041 pix_en_i toggled 1-in-4 -> all timings scale by 4; outputs stable on held clocks; counts identical to REQ-038.
REQ-042 H_VISIBLE = 4, H_FRONT = H_SYNC = H_BACK = 1, V_VISIBLE = 2, V_FRONT = V_SYNC = V_BACK = 1, HSYNC_POL = VSYNC_POL = 1, FW = 2 -> hsync_o high only at h = 5, vsync_o high only at v = 3, frame_count_o wraps 3 -> 0 after 4 frames of 35 clocks.
REQ-043 Assert rst_ni low asynchronously at h = 300, v = 200 -> outputs reach REQ-036 values before the next clock edge; after release, counting restarts from 0/0.
